// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: fetch state encoding and PC/instruction constants.
// The control decoder also uses NOP.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_HOLD  = 2'd2,
        FETCH_FLUSH = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/mips_pc.sv
// Program counter and pending-redirect registers with the next-PC mux.
// A redirect always takes priority over the pending target and the sequential step.
module mips_pc
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_step,
    input  logic        pc_redirect,
    input  logic        pc_from_pend,
    input  logic        pend_load,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc
);

    logic [31:0] pend_pc;
    logic [31:0] next_pc;
    logic [31:0] target_pc;

    assign target_pc = word_align(redirect_pc);

    always_comb begin
        next_pc = pc;
        if (pc_redirect) begin
            next_pc = target_pc;
        end else if (pc_from_pend) begin
            next_pc = pend_pc;
        end else if (pc_step) begin
            next_pc = pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= word_align(RESET_PC);
            pend_pc <= word_align(RESET_PC);
        end else begin
            pc <= next_pc;
            if (pend_load) begin
                pend_pc <= target_pc;
            end
        end
    end

endmodule

// File: rtl/mips_fetch.sv
// Instruction fetch stage: req/ack to instruction memory, valid/ready to decode.
// Redirects flush held or in-flight instructions; an open request is completed before retargeting.
module mips_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         pc_step;
    logic         pc_redirect;
    logic         pc_from_pend;
    logic         pend_load;

    assign imem_addr = pc;

    // pc only moves on a completed request or a redirect out of HOLD,
    // so the address stays stable through REQ waits and FLUSH.
    always_comb begin
        pc_step      = 1'b0;
        pc_redirect  = 1'b0;
        pc_from_pend = 1'b0;
        pend_load    = 1'b0;
        case (state)
            FETCH_REQ: begin
                pc_step     = imem_ack && !redirect;
                pc_redirect = imem_ack && redirect;
                pend_load   = !imem_ack && redirect;
            end
            FETCH_HOLD: begin
                pc_redirect = redirect;
            end
            FETCH_FLUSH: begin
                pc_redirect  = imem_ack && redirect;
                pc_from_pend = imem_ack && !redirect;
                pend_load    = !imem_ack && redirect;
            end
            default: ;
        endcase
    end

    mips_pc #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_step     (pc_step),
        .pc_redirect (pc_redirect),
        .pc_from_pend(pc_from_pend),
        .pend_load   (pend_load),
        .redirect_pc (redirect_pc),
        .pc          (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH_IDLE;
            imem_req    <= 1'b0;
            instr       <= NOP;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    state    <= FETCH_REQ;
                    imem_req <= 1'b1;
                end
                FETCH_REQ: begin
                    if (imem_ack) begin
                        if (!redirect) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= FETCH_HOLD;
                            imem_req    <= 1'b0;
                        end
                    end else if (redirect) begin
                        state <= FETCH_FLUSH;
                    end
                end
                FETCH_HOLD: begin
                    if (redirect || instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH_REQ;
                        imem_req    <= 1'b1;
                    end
                end
                FETCH_FLUSH: begin
                    if (imem_ack) begin
                        state <= FETCH_REQ;
                    end
                end
                default: begin
                    state    <= FETCH_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch.sv
// Bench for mips_fetch: directed scenarios plus randomized traffic checked against
// a program-order model of the delivered instruction stream.
module tb_mips_fetch;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    mips_fetch #(
        .RESET_PC(RST_PC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    // Program-order model: every delivered instruction must be the next one in
    // sequence from reset or from the most recent redirect target.
    logic [31:0] exp_pc;
    int unsigned xfers = 0;
    logic        p_ok = 1'b0;
    logic        p_req, p_ack, p_valid, p_ready, p_redir;
    logic [31:0] p_addr, p_instr, p_ipc;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = RST_PC;
            p_ok   = 1'b0;
        end else begin
            if (p_ok && p_req && !p_ack) begin
                tests++;
                if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
                    fails++;
                    $display("FAIL addr_stable t=%0t got req=%b addr=%h exp req=1 addr=%h",
                             $time, imem_req, imem_addr, p_addr);
                end
            end
            if (p_ok && p_valid && !p_ready && !p_redir) begin
                tests++;
                if (instr_valid !== 1'b1 || instr !== p_instr || instr_pc !== p_ipc) begin
                    fails++;
                    $display("FAIL instr_hold t=%0t got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                             $time, instr_valid, instr_pc, instr, p_ipc, p_instr);
                end
            end
            if (instr_valid && instr_ready) begin
                tests++;
                if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                    fails++;
                    $display("FAIL stream_order t=%0t got pc=%h i=%h exp pc=%h i=%h",
                             $time, instr_pc, instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                xfers++;
            end
            if (redirect) exp_pc = redirect_pc & ~32'd3;
            p_ok    = 1'b1;
            p_req   = imem_req;
            p_ack   = imem_ack;
            p_valid = instr_valid;
            p_ready = instr_ready;
            p_redir = redirect;
            p_addr  = imem_addr;
            p_instr = instr;
            p_ipc   = instr_pc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC || instr !== 32'h0 ||
            instr_pc !== 32'h0 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_vals got req=%b addr=%h i=%h pc=%h v=%b exp req=0 addr=%h rest 0",
                     imem_req, imem_addr, instr, instr_pc, instr_valid, RST_PC);
        end
        rst_n = 1'b1;
        tests++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL idle_cycle got req=%b exp 0", imem_req);
        end
        tick();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            fails++;
            $display("FAIL first_req got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = RST_PC + 32'(4 * i);
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== a) begin
                fails++;
                $display("FAIL seq_req%0d got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, a);
            end
            imem_ack = 1'b1;
            tick();
            tests++;
            if (instr_valid !== 1'b1 || instr_pc !== a || instr !== mem_word(a) || imem_req !== 1'b0) begin
                fails++;
                $display("FAIL seq_cap%0d got v=%b pc=%h i=%h req=%b exp v=1 pc=%h i=%h req=0",
                         i, instr_valid, instr_pc, instr, imem_req, a, mem_word(a));
            end
            if (i < 2) begin
                tick();
                tests++;
                if (instr_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL seq_gap%0d got v=%b exp 0", i, instr_valid);
                end
            end
        end
    endtask

    task automatic test_wait_hold();
        imem_ack = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0040_000C || instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL wait_req%0d got req=%b addr=%h v=%b exp req=1 addr=0040000c v=0",
                         i, imem_req, imem_addr, instr_valid);
            end
            if (i < 3) tick();
        end
        imem_ack = 1'b1; instr_ready = 1'b0;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h0040_000C ||
                instr !== mem_word(32'h0040_000C) || imem_req !== 1'b0) begin
                fails++;
                $display("FAIL hold%0d got v=%b pc=%h i=%h req=%b exp v=1 pc=0040000c req=0",
                         i, instr_valid, instr_pc, instr, imem_req);
            end
        end
        instr_ready = 1'b1;
        tick();
        tests++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0010) begin
            fails++;
            $display("FAIL hold_release got v=%b req=%b addr=%h exp v=0 req=1 addr=00400010",
                     instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_hold();
        imem_ack = 1'b1; instr_ready = 1'b0;
        tick();
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_1003;
        tick();
        redirect = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_1000) begin
            fails++;
            $display("FAIL redir_hold got v=%b req=%b addr=%h exp v=0 req=1 addr=00001000",
                     instr_valid, imem_req, imem_addr);
        end
        imem_ack = 1'b1; instr_ready = 1'b1;
        tick();
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_1000) begin
            fails++;
            $display("FAIL redir_hold_cap got v=%b pc=%h exp v=1 pc=00001000", instr_valid, instr_pc);
        end
    endtask

    task automatic test_redirect_flush();
        imem_ack = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_3000;
        tick();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1004 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_old1 got req=%b addr=%h v=%b exp req=1 addr=00001004 v=0",
                     imem_req, imem_addr, instr_valid);
        end
        redirect_pc = 32'h0000_2000;
        tick();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1004 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_old2 got req=%b addr=%h v=%b exp req=1 addr=00001004 v=0",
                     imem_req, imem_addr, instr_valid);
        end
        redirect = 1'b0; imem_ack = 1'b1;
        tick();
        tests++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_2000) begin
            fails++;
            $display("FAIL flush_new got v=%b req=%b addr=%h exp v=0 req=1 addr=00002000",
                     instr_valid, imem_req, imem_addr);
        end
        tick();
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_2000) begin
            fails++;
            $display("FAIL flush_cap got v=%b pc=%h exp v=1 pc=00002000", instr_valid, instr_pc);
        end
    endtask

    task automatic test_redirect_ack();
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_5008;
        tick();
        redirect = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_5008) begin
            fails++;
            $display("FAIL redir_ack got v=%b req=%b addr=%h exp v=0 req=1 addr=00005008",
                     instr_valid, imem_req, imem_addr);
        end
        tick();
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_5008) begin
            fails++;
            $display("FAIL redir_ack_cap got v=%b pc=%h exp v=1 pc=00005008", instr_valid, instr_pc);
        end
    endtask

    task automatic test_wrap_and_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; imem_ack = 1'b0;
        tick();
        redirect = 1'b0; imem_ack = 1'b1;
        tick();
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
            fails++;
            $display("FAIL wrap_cap got v=%b pc=%h exp v=1 pc=fffffffc", instr_valid, instr_pc);
        end
        imem_ack = 1'b0;
        tick();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
            fails++;
            $display("FAIL wrap_next got req=%b addr=%h exp req=1 addr=00000000", imem_req, imem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC || instr !== 32'h0 ||
            instr_pc !== 32'h0 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got req=%b addr=%h i=%h pc=%h v=%b exp req=0 addr=%h rest 0",
                     imem_req, imem_addr, instr, instr_pc, instr_valid, RST_PC);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            fails++;
            $display("FAIL restart got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_random();
        int unsigned wait_cnt = 0;
        int unsigned start = xfers;
        for (int c = 0; c < 3000; c++) begin
            redirect    = !redirect && ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            instr_ready = ($urandom_range(0, 3) != 0);
            if (imem_req) begin
                if (wait_cnt == 0) begin
                    imem_ack = 1'b1;
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt--;
                end
            end else begin
                imem_ack = 1'b0;
            end
            tick();
        end
        redirect = 1'b0;
        imem_ack = 1'b0;
        tests++;
        if (xfers - start < 100) begin
            fails++;
            $display("FAIL random_progress got %0d transfers exp at least 100", xfers - start);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_hold();
        test_redirect_hold();
        test_redirect_flush();
        test_redirect_ack();
        test_wrap_and_reset();
        test_random();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
